// File: rtl/seq_mult_hs.sv
// seq_mult_hs: sequential shift-add multiplier with signed/unsigned mode and start/busy/done handshake.
// Ports: clk, rst_n (async active-low); start, signed_mode, ain, bin sampled when idle;
// busy high during an operation; done pulses one cycle with a new 2*WIDTH-bit product on yout.
module seq_mult_hs #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   ain,
  input  logic [WIDTH-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] yout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] a, b, a_mag, b_mag;
  logic neg;
  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign a_mag = (signed_mode && ain[WIDTH-1]) ? -ain : ain;
  assign b_mag = (signed_mode && bin[WIDTH-1]) ? -bin : bin;
  always_comb begin
    state_nx = IDLE;
    busy = state != IDLE;
    state_nx = state == IDLE ? (start ? CALC : IDLE) :
               state == CALC ? (count == CW'(WIDTH - 1) ? FIN : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      yout  <= '0;
      count <= '0;
      acc   <= '0;
      a     <= '0;
      b     <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= state == FIN;
      if (state == IDLE && start) begin
        a     <= a_mag;
        b     <= b_mag;
        neg   <= signed_mode & (ain[WIDTH-1] ^ bin[WIDTH-1]);
        acc   <= '0;
        count <= '0;
      end
      if (state == CALC) begin
        if (b[count]) acc <= acc + ({{WIDTH{1'b0}}, a} << count);
        count <= count + 1'b1;
      end
      if (state == FIN) yout <= neg ? -acc : acc;
    end
  end
endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: directed checks of seq_mult_hs (WIDTH 16 and 8) against a cycle-level behavioural model.
module tb_seq_mult_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start16 = 1'b0, mode16 = 1'b0, busy16, done16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] y16;
  logic start8 = 1'b0, mode8 = 1'b0, busy8, done8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] y8;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  seq_mult_hs #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(mode16),
    .ain(a16), .bin(b16), .busy(busy16), .done(done16), .yout(y16));

  seq_mult_hs #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(mode8),
    .ain(a8), .bin(b8), .busy(busy8), .done(done8), .yout(y8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] prod(input int w, input bit s, input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa -= (longint'(1) << w);
    if (s && b[w-1]) sb -= (longint'(1) << w);
    p = sa * sb;
    return 32'(p) & 32'((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Model: an accepted operation keeps the unit busy for WIDTH+1 cycles, then the product appears with done.
  int rem16 = 0, rem8 = 0;
  logic [31:0] pend16 = '0, ey16 = '0, pend8 = '0, ey8 = '0;
  logic ed16 = 1'b0, ed8 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem16 <= 0; ey16 <= '0; ed16 <= 1'b0;
    end else if (rem16 == 0) begin
      ed16 <= 1'b0;
      if (start16) begin
        rem16  <= 17;
        pend16 <= prod(16, mode16, a16, b16);
      end
    end else begin
      rem16 <= rem16 - 1;
      ed16  <= rem16 == 1;
      if (rem16 == 1) ey16 <= pend16;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem8 <= 0; ey8 <= '0; ed8 <= 1'b0;
    end else if (rem8 == 0) begin
      ed8 <= 1'b0;
      if (start8) begin
        rem8  <= 9;
        pend8 <= prod(8, mode8, {8'h00, a8}, {8'h00, b8});
      end
    end else begin
      rem8 <= rem8 - 1;
      ed8  <= rem8 == 1;
      if (rem8 == 1) ey8 <= pend8;
    end
  end

  always @(negedge clk) begin
    chk("busy16", {31'b0, busy16}, {31'b0, rem16 != 0});
    chk("done16", {31'b0, done16}, {31'b0, ed16});
    chk("yout16", y16, ey16);
    chk("busy8", {31'b0, busy8}, {31'b0, rem8 != 0});
    chk("done8", {31'b0, done8}, {31'b0, ed8});
    chk("yout8", {16'b0, y8}, ey8);
  end

  task automatic op(input bit w8, input bit s, input logic [15:0] a, input logic [15:0] b,
                    input logic [31:0] lit, input bit disturb);
    int n;
    @(negedge clk);
    if (w8) begin
      start8 = 1'b1; mode8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = 1'b1; mode16 = s; a16 = a; b16 = b;
    end
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    n = 1;
    while (!(w8 ? done8 : done16) && n < 60) begin
      if (disturb && n == 5) begin
        start16 = 1'b1; a16 = 16'h5555; b16 = 16'h0F0F; mode16 = ~mode16;
      end
      if (disturb && n == 6) start16 = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("latency", n, w8 ? 10 : 18);
    chk("yout_lit", w8 ? {16'b0, y8} : y16, lit);
    chk("busy_at_done", {31'b0, w8 ? busy8 : busy16}, 0);
  endtask

  logic [15:0] pa [4] = '{16'd7, 16'd100, 16'h1234, 16'h00AA};
  logic [15:0] pb [4] = '{16'd9, 16'd200, 16'h0010, 16'h0003};
  logic [31:0] pl [3] = '{32'd63, 32'h00004E20, 32'h00012340};

  initial begin
    int n, dc;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy16}, 0);
    chk("rst_done", {31'b0, done16}, 0);
    chk("rst_yout", y16, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(0, 0, 16'd3, 16'd5, 32'h0000000F, 0);
    op(0, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
    op(0, 1, 16'hFFFF, 16'hFFFF, 32'h00000001, 0);
    op(0, 1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 0);
    op(0, 1, 16'h8000, 16'h8000, 32'h40000000, 0);
    op(0, 1, 16'h8000, 16'h0001, 32'hFFFF8000, 0);
    op(0, 1, 16'h0000, 16'h8000, 32'h00000000, 0);
    op(0, 0, 16'd3, 16'd7, 32'd21, 1);
    op(1, 1, 16'h0080, 16'h0080, 32'h00004000, 0);
    op(1, 0, 16'h00FF, 16'h0002, 32'h000001FE, 0);
    @(negedge clk);
    start16 = 1'b1; mode16 = 1'b0; a16 = pa[0]; b16 = pb[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done16 && n < 60);
      chk("b2b_interval", n, 18);
      chk("b2b_yout", y16, pl[k]);
      a16 = pa[k+1];
      b16 = pb[k+1];
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy16}, 0);
    chk("abort_done", {31'b0, done16}, 0);
    chk("abort_yout", y16, 0);
    @(negedge clk);
    start16 = 1'b0;
    rst_n = 1'b1;
    dc = 0;
    repeat (25) begin
      @(negedge clk);
      if (done16) dc++;
    end
    chk("no_done_after_abort", dc, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
